video_stream_source: RTL and testbench

VIDEO_STREAM_SOURCE -- requirements
Module: video_stream_source

---
 rtl/video_stream_source.sv | 169 ++++++++++++++++
 tb/tb_video_stream_source.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_source.sv
// rtl/video_stream_source.sv - test-pattern video source with an AXI-Stream video master port
module video_stream_source (
  input  logic        m_axis_vid_aclk,
  input  logic        aresetn,
  output logic [31:0] m_axis_vid_tdata,
  output logic        m_axis_vid_tvalid,
  input  logic        m_axis_vid_tready,
  output logic        m_axis_vid_tuser,
  output logic        m_axis_vid_tlast,
  input  logic [31:0] control_data,
  input  logic [7:0]  control_op,
  output logic        frame_busy,
  output logic        frame_done
);
  localparam logic [7:0]  OP_DIMENSIONS = 8'd2;
  localparam logic [7:0]  OP_VSYNC      = 8'd5;
  localparam logic [7:0]  OP_RESET      = 8'd11;
  localparam logic [7:0]  OP_PATTERN    = 8'd18;
  localparam logic [7:0]  OP_COLOR      = 8'd19;
  localparam logic [11:0] DEF_WIDTH     = 12'd720;
  localparam logic [11:0] DEF_HEIGHT    = 12'd576;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t      state;
  logic [7:0]  op_q;
  logic [27:0] data_q;
  logic [11:0] cfg_width, cfg_height, width, height;
  logic [1:0]  cfg_mode, mode;
  logic [23:0] cfg_color, color;
  logic        cfg_free_run;
  logic [11:0] x, y, nx, ny;
  logic [7:0]  frame_cnt;
  logic        xfer, line_end, frame_end, vsync_ok, restart;
  logic        unused_data;

  assign unused_data = ^control_data[31:28];

  function automatic logic [31:0] pixel(input logic [1:0] m, input logic [23:0] c,
                                        input logic [8:0] px, input logic [7:0] py,
                                        input logic [7:0] fc);
    logic [23:0] bar;
    case (px[8:6])
      3'd0:    bar = 24'hffffff;
      3'd1:    bar = 24'h00ffff;
      3'd2:    bar = 24'hffff00;
      3'd3:    bar = 24'h00ff00;
      3'd4:    bar = 24'hff00ff;
      3'd5:    bar = 24'h0000ff;
      3'd6:    bar = 24'hff0000;
      default: bar = 24'h000000;
    endcase
    case (m)
      2'd0:    pixel = {8'h00, c};
      2'd1:    pixel = {8'h00, px[7:0], px[7:0], px[7:0]};
      2'd2:    pixel = {8'h00, bar};
      default: pixel = {8'h00, fc, py, px[7:0]};
    endcase
  endfunction

  assign xfer      = m_axis_vid_tvalid && m_axis_vid_tready;
  assign line_end  = (x == width - 12'd1);
  assign frame_end = line_end && (y == height - 12'd1);
  assign nx        = line_end ? 12'd0 : x + 12'd1;
  assign ny        = line_end ? y + 12'd1 : y;
  assign vsync_ok  = (op_q == OP_VSYNC) && (cfg_width != 12'd0) && (cfg_height != 12'd0);
  assign restart   = cfg_free_run && (cfg_width != 12'd0) && (cfg_height != 12'd0);

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      state             <= IDLE;
      op_q              <= 8'd0;
      data_q            <= 28'd0;
      cfg_width         <= DEF_WIDTH;
      cfg_height        <= DEF_HEIGHT;
      cfg_mode          <= 2'd0;
      cfg_color         <= 24'h000000;
      cfg_free_run      <= 1'b0;
      width             <= DEF_WIDTH;
      height            <= DEF_HEIGHT;
      mode              <= 2'd0;
      color             <= 24'h000000;
      x                 <= 12'd0;
      y                 <= 12'd0;
      frame_cnt         <= 8'd0;
      m_axis_vid_tdata  <= 32'd0;
      m_axis_vid_tvalid <= 1'b0;
      m_axis_vid_tuser  <= 1'b0;
      m_axis_vid_tlast  <= 1'b0;
      frame_busy        <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      op_q       <= control_op;
      data_q     <= control_data[27:0];
      frame_done <= 1'b0;

      case (op_q)
        OP_DIMENSIONS: begin
          cfg_height <= data_q[27:16];
          cfg_width  <= data_q[11:0];
        end
        OP_RESET: begin
          cfg_width    <= DEF_WIDTH;
          cfg_height   <= DEF_HEIGHT;
          cfg_mode     <= 2'd0;
          cfg_color    <= 24'h000000;
          cfg_free_run <= 1'b0;
        end
        OP_PATTERN: begin
          cfg_mode     <= data_q[1:0];
          cfg_free_run <= data_q[8];
        end
        OP_COLOR: cfg_color <= data_q[23:0];
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (vsync_ok) begin
            state             <= STREAM;
            frame_busy        <= 1'b1;
            width             <= cfg_width;
            height            <= cfg_height;
            mode              <= cfg_mode;
            color             <= cfg_color;
            x                 <= 12'd0;
            y                 <= 12'd0;
            m_axis_vid_tvalid <= 1'b1;
            m_axis_vid_tuser  <= 1'b1;
            m_axis_vid_tlast  <= (cfg_width == 12'd1);
            m_axis_vid_tdata  <= pixel(cfg_mode, cfg_color, 9'd0, 8'd0, frame_cnt);
          end
        end
        STREAM: begin
          if (xfer) begin
            m_axis_vid_tuser <= 1'b0;
            if (frame_end) begin
              frame_done <= 1'b1;
              if (restart) begin
                // Back-to-back frame: parameters re-latched from the live config.
                frame_cnt        <= frame_cnt + 8'd1;
                width            <= cfg_width;
                height           <= cfg_height;
                mode             <= cfg_mode;
                color            <= cfg_color;
                x                <= 12'd0;
                y                <= 12'd0;
                m_axis_vid_tuser <= 1'b1;
                m_axis_vid_tlast <= (cfg_width == 12'd1);
                m_axis_vid_tdata <= pixel(cfg_mode, cfg_color, 9'd0, 8'd0, frame_cnt + 8'd1);
              end else begin
                state             <= IDLE;
                frame_busy        <= 1'b0;
                m_axis_vid_tvalid <= 1'b0;
                m_axis_vid_tlast  <= 1'b0;
              end
            end else begin
              x                <= nx;
              y                <= ny;
              m_axis_vid_tlast <= (nx == width - 12'd1);
              m_axis_vid_tdata <= pixel(mode, color, nx[8:0], ny[7:0], frame_cnt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_video_stream_source.sv
// tb/tb_video_stream_source.sv - directed self-checking bench for video_stream_source
module tb_video_stream_source;
  logic        clk;
  logic        aresetn;
  logic [31:0] tdata;
  logic        tvalid, tready, tuser, tlast;
  logic [31:0] control_data;
  logic [7:0]  control_op;
  logic        frame_busy, frame_done;

  int checks = 0;
  int failures = 0;
  int nbeats, ncyc, nlast;
  logic [31:0] bd [0:1023];
  logic        bu [0:1023];
  logic        bl [0:1023];
  logic        seen_v, seen_d;

  video_stream_source dut (
    .m_axis_vid_aclk  (clk),
    .aresetn          (aresetn),
    .m_axis_vid_tdata (tdata),
    .m_axis_vid_tvalid(tvalid),
    .m_axis_vid_tready(tready),
    .m_axis_vid_tuser (tuser),
    .m_axis_vid_tlast (tlast),
    .control_data     (control_data),
    .control_op       (control_op),
    .frame_busy       (frame_busy),
    .frame_done       (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [7:0] o, input logic [31:0] d);
    @(negedge clk);
    control_op = o;
    control_data = d;
    @(negedge clk);
    control_op = 8'd0;
    control_data = 32'd0;
  endtask

  // Sink model: records accepted beats and verifies the master holds its beat while stalled.
  task automatic run_beats(input int n, input bit rnd, input int budget);
    logic        held;
    logic [33:0] h;
    nbeats = 0;
    ncyc = 0;
    held = 1'b0;
    h = '0;
    while (nbeats < n && ncyc < budget) begin
      @(negedge clk);
      ncyc++;
      if (held) check("stall_hold", {tvalid, tuser, tlast, tdata}, {1'b1, h});
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid && tready) begin
        bd[nbeats] = tdata;
        bu[nbeats] = tuser;
        bl[nbeats] = tlast;
        nbeats++;
        held = 1'b0;
      end else begin
        held = tvalid;
        h = {tuser, tlast, tdata};
      end
    end
    if (nbeats < n) check("beat_timeout", 64'(nbeats), 64'(n));
  endtask

  initial begin
    aresetn = 1'b0;
    tready = 1'b0;
    control_op = 8'd0;
    control_data = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tuser", tuser, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_busy", frame_busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    aresetn = 1'b1;

    // Solid 4x2 frame
    op(8'd2, 32'h0002_0004);
    op(8'd19, 32'h0011_2233);
    op(8'd5, 32'd0);
    check("vsync_pre_tvalid", tvalid, 1'b0);
    @(negedge clk);
    check("vsync_tvalid", tvalid, 1'b1);
    check("vsync_tuser", tuser, 1'b1);
    check("vsync_busy", frame_busy, 1'b1);
    run_beats(8, 1'b0, 50);
    for (int i = 0; i < 8; i++) begin
      check("solid_data", bd[i], 32'h0011_2233);
      check("solid_user", bu[i], i == 0);
      check("solid_last", bl[i], (i == 3) || (i == 7));
    end
    @(negedge clk);
    check("solid_end_tvalid", tvalid, 1'b0);
    check("solid_end_done", frame_done, 1'b1);
    check("solid_end_busy", frame_busy, 1'b0);
    @(negedge clk);
    check("solid_done_pulse", frame_done, 1'b0);

    // Ramp 4x1 under random backpressure
    op(8'd18, 32'h0000_0001);
    op(8'd2, 32'h0001_0004);
    op(8'd5, 32'd0);
    run_beats(4, 1'b1, 300);
    for (int i = 0; i < 4; i++) begin
      check("ramp_data", bd[i], 32'h0001_0101 * i);
      check("ramp_user", bu[i], i == 0);
      check("ramp_last", bl[i], i == 3);
    end
    @(negedge clk);
    check("ramp_end_tvalid", tvalid, 1'b0);
    check("ramp_end_done", frame_done, 1'b1);

    // Mode 3 free-run 2x2: frames back to back, then stop after the third
    op(8'd18, 32'h0000_0103);
    op(8'd2, 32'h0002_0002);
    op(8'd5, 32'd0);
    run_beats(8, 1'b0, 50);
    check("fr_no_gap", 64'(ncyc), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("fr_data", bd[i], {8'h00, 8'(i / 4), 8'((i % 4) / 2), 8'(i % 2)});
      check("fr_user", bu[i], (i % 4) == 0);
      check("fr_last", bl[i], (i % 2) == 1);
    end
    @(negedge clk);
    tready = 1'b0;
    check("fr2_start_user", tuser, 1'b1);
    check("fr2_start_data", tdata, 32'h0002_0000);
    op(8'd18, 32'h0000_0003);
    run_beats(4, 1'b0, 50);
    check("fr2_last_data", bd[3], 32'h0002_0101);
    @(negedge clk);
    check("fr_stop_tvalid", tvalid, 1'b0);
    check("fr_stop_done", frame_done, 1'b1);

    // Dimensions changed mid-frame apply to the next frame only
    op(8'd18, 32'h0000_0000);
    op(8'd2, 32'h0002_0004);
    op(8'd19, 32'h0044_5566);
    op(8'd5, 32'd0);
    run_beats(3, 1'b0, 50);
    @(negedge clk);
    tready = 1'b0;
    op(8'd2, 32'h0008_0008);
    run_beats(5, 1'b0, 50);
    check("mid_b3_last", bl[0], 1'b1);
    check("mid_b7_last", bl[4], 1'b1);
    check("mid_b7_data", bd[4], 32'h0044_5566);
    @(negedge clk);
    check("mid_end_tvalid", tvalid, 1'b0);
    op(8'd5, 32'd0);
    run_beats(64, 1'b0, 200);
    nlast = 0;
    for (int i = 0; i < 64; i++) if (bl[i]) nlast++;
    check("big_nlast", 64'(nlast), 64'd8);
    check("big_user0", bu[0], 1'b1);
    check("big_last63", bl[63], 1'b1);
    check("big_cycles", 64'(ncyc), 64'd64);
    @(negedge clk);
    check("big_end_tvalid", tvalid, 1'b0);
    check("big_end_done", frame_done, 1'b1);

    // Reset mid-frame aborts, defaults come back
    op(8'd2, 32'h0002_0004);
    op(8'd5, 32'd0);
    run_beats(3, 1'b0, 50);
    @(negedge clk);
    check("abort_b3_valid", tvalid, 1'b1);
    aresetn = 1'b0;
    @(negedge clk);
    check("abort_tvalid", tvalid, 1'b0);
    check("abort_busy", frame_busy, 1'b0);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_stays_idle", tvalid, 1'b0);
    op(8'd5, 32'd0);
    run_beats(720, 1'b0, 800);
    check("dflt_user0", bu[0], 1'b1);
    check("dflt_data0", bd[0], 32'h0000_0000);
    check("dflt_last718", bl[718], 1'b0);
    check("dflt_last719", bl[719], 1'b1);
    check("dflt_cycles", 64'(ncyc), 64'd720);
    @(negedge clk);
    check("dflt_row1_valid", tvalid, 1'b1);
    check("dflt_row1_user", tuser, 1'b0);
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;

    // Zero width: VSYNC ignored
    op(8'd2, 32'h0004_0000);
    op(8'd5, 32'd0);
    tready = 1'b1;
    seen_v = 1'b0;
    seen_d = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_v |= tvalid;
      seen_d |= frame_done;
    end
    check("zero_w_tvalid", seen_v, 1'b0);
    check("zero_w_done", seen_d, 1'b0);

    // OP_RESET restores a usable default geometry
    op(8'd11, 32'd0);
    op(8'd5, 32'd0);
    @(negedge clk);
    check("opreset_tvalid", tvalid, 1'b1);
    check("opreset_tuser", tuser, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
